// File: rtl/multiplier_pkg.sv
// Shared definitions for the shift-add multiplier.
//   state_t          : control FSM state encoding
//   DEF_DATA_WIDTH   : default operand width
//   DEF_FRAC_BITS    : default operand fraction bits (Q12.4 in, Q24.8 out)
package multiplier_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRAC_BITS  = 4;

  // Each strobe is a dedicated state bit, so decoding rd/wr is a plain flop
  // output and cannot glitch during state transitions.
  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    READ    = 3'b001,
    WRITE   = 3'b010,
    COMPUTE = 3'b100
  } state_t;

endpackage

// File: rtl/multiplier_module_shift_add_datapath.sv
// Iterative shift-add datapath: one multiplier bit per step, LSB first.
//   clk, reset_n : clock, async active-low reset
//   i_load       : latch operands and clear accumulator / counter
//   i_step       : process one multiplier bit
//   i_mcand      : multiplicand
//   i_mplier     : multiplier
//   o_last       : current step is the final one
//   o_product    : registered product, updated on the final step only
module shift_add_datapath
  import multiplier_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_load,
  input  logic                    i_step,
  input  logic [DATA_WIDTH-1:0]   i_mcand,
  input  logic [DATA_WIDTH-1:0]   i_mplier,
  output logic                    o_last,
  output logic [2*DATA_WIDTH-1:0] o_product
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [2*DATA_WIDTH-1:0] r_acc;
  logic [2*DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0]   r_mplier;
  logic [CW-1:0]           r_cnt;
  logic [2*DATA_WIDTH-1:0] r_product;

  logic [2*DATA_WIDTH-1:0] w_addend;
  logic [2*DATA_WIDTH-1:0] w_sum;

  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign w_sum    = r_acc + w_addend;
  assign o_last   = (r_cnt == CW'(DATA_WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= {{DATA_WIDTH{1'b0}}, i_mcand};
      r_mplier <= i_mplier;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      // Publish the finished sum directly so the product is visible on the
      // same edge that enters WRITE.
      if (o_last) r_product <= w_sum;
    end
  end

  assign o_product = r_product;

endmodule

// File: rtl/multiplier_module.sv
// Unsigned fixed-point multiplier (QI.F x QI.F -> Q2I.2F), one product per
// DATA_WIDTH+2 cycles: READ (1) + COMPUTE (DATA_WIDTH) + WRITE (1).
//   clk      : clock
//   reset_n  : async active-low reset, aborts any operation in flight
//   entry_1  : multiplicand, sampled only while rd=1
//   entry_2  : multiplier, sampled only while rd=1
//   rd       : upstream read strobe (one cycle, READ state)
//   wr       : downstream write strobe (one cycle, WRITE state)
//   output_1 : registered product, binary point at bit 2*FRAC_BITS
module multiplier_module
  import multiplier_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_WIDTH-1:0]   entry_1,
  input  logic [DATA_WIDTH-1:0]   entry_2,
  output logic                    rd,
  output logic                    wr,
  output logic [2*DATA_WIDTH-1:0] output_1
);

  // Fraction bits only place the binary point; reject nonsense at elaboration.
  if (FRAC_BITS > DATA_WIDTH) begin : g_frac_range
    $error("FRAC_BITS exceeds DATA_WIDTH");
  end

  state_t r_state;
  state_t w_state_nxt;
  logic   w_last;
  logic   w_step;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = READ;
      READ:    w_state_nxt = COMPUTE;
      COMPUTE: if (w_last) w_state_nxt = WRITE;
      WRITE:   w_state_nxt = READ;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd     = r_state[0];
    wr     = r_state[1];
    w_step = r_state[2];
  end

  shift_add_datapath #(.DATA_WIDTH(DATA_WIDTH)) u_dp (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (rd),
    .i_step    (w_step),
    .i_mcand   (entry_1),
    .i_mplier  (entry_2),
    .o_last    (w_last),
    .o_product (output_1)
  );

endmodule

// File: tb/tb_multiplier_module.sv
module tb_multiplier_module;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] entry_1 = '0;
  logic [15:0] entry_2 = '0;
  logic        rd;
  logic        wr;
  logic [31:0] output_1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int coincide = 0;

  multiplier_module #(.DATA_WIDTH(16), .FRAC_BITS(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .entry_1  (entry_1),
    .entry_2  (entry_2),
    .rd       (rd),
    .wr       (wr),
    .output_1 (output_1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (rd === 1'b1 && wr === 1'b1) coincide++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits for rd, lets the DUT run one operation, returns the product seen
  // on the wr cycle and the number of cycles from rd to wr.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit scramble,
                       output logic [31:0] res, output int lat, output int rd_cyc,
                       output bit ok);
    int n;
    ok = 1'b0; lat = 0; res = '0; rd_cyc = 0;
    entry_1 = a; entry_2 = b;
    n = 0;
    while (rd !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (rd !== 1'b1) return;
    rd_cyc = cyc;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (scramble) begin entry_1 = 16'($urandom); entry_2 = 16'($urandom); end
    end while (wr !== 1'b1 && n < 40);
    if (wr === 1'b1) begin ok = 1'b1; lat = n; res = output_1; end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (rd !== 1'b0 || wr !== 1'b0 || output_1 !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: rd=%b wr=%b out=%h, need 0 0 00000000", i, rd, wr, output_1);
      end
    end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (rd !== 1'b0) begin n_fail++; $display("FAIL reset_release_rd0: rd=%b, need 0", rd); end
    @(negedge clk);
    n_checks++;
    if (rd !== 1'b1) begin n_fail++; $display("FAIL reset_first_rd: rd=%b after 1st edge, need 1", rd); end
  endtask

  task automatic test_product(input string name, input logic [15:0] a, input logic [15:0] b,
                              input bit scramble, input logic [31:0] expv);
    logic [31:0] res; int lat; int rc; bit ok;
    do_op(a, b, scramble, res, lat, rc, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s_timeout: no rd/wr seen", name); end
    n_checks++;
    if (lat !== 17) begin n_fail++; $display("FAIL %s_latency: %0d cycles rd->wr, need 17", name, lat); end
    n_checks++;
    if (res !== expv) begin n_fail++; $display("FAIL %s_value: out=%h, need %h", name, res, expv); end
  endtask

  // Product from the previous operation must survive the next READ/COMPUTE.
  task automatic test_hold(input logic [31:0] prev);
    int n;
    n = 0;
    while (rd !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    repeat (6) @(negedge clk);
    n_checks++;
    if (output_1 !== prev || wr !== 1'b0) begin
      n_fail++; $display("FAIL hold: out=%h wr=%b mid-compute, need %h 0", output_1, wr, prev);
    end
  endtask

  task automatic test_abort();
    int n;
    entry_1 = 16'hFFFF; entry_2 = 16'hFFFF;
    n = 0;
    while (rd !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    repeat (8) @(negedge clk);  // now in the 8th COMPUTE cycle
    n_checks++;
    if (wr !== 1'b0 || output_1 !== 32'h00001C03) begin
      n_fail++; $display("FAIL abort_pre: wr=%b out=%h, need 0 00001c03", wr, output_1);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (output_1 !== 32'h0 || rd !== 1'b0 || wr !== 1'b0) begin
      n_fail++; $display("FAIL abort_clear: out=%h rd=%b wr=%b, need 00000000 0 0", output_1, rd, wr);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (wr !== 1'b0) begin n_fail++; $display("FAIL abort_no_wr: wr=%b in reset, need 0", wr); end
    end
    reset_n = 1'b1;
    test_product("abort_restart", 16'h0065, 16'h0047, 1'b0, 32'h00001C03);
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; int lat; int rc[3]; bit ok;
    logic [15:0] av[3]; logic [15:0] bv[3]; logic [31:0] ev[3];
    int c0;
    av = '{16'h0003, 16'h0100, 16'h8001};
    bv = '{16'h0005, 16'h0100, 16'h0002};
    ev = '{32'h0000000F, 32'h00010000, 32'h00010002};
    c0 = coincide;
    for (int i = 0; i < 3; i++) begin
      do_op(av[i], bv[i], 1'b0, res, lat, rc[i], ok);
      n_checks++;
      if (!ok || lat !== 17 || res !== ev[i]) begin
        n_fail++; $display("FAIL b2b_op%0d: ok=%b lat=%0d out=%h, need 1 17 %h", i, ok, lat, res, ev[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      n_checks++;
      if (rc[i] - rc[i-1] !== 18) begin
        n_fail++; $display("FAIL b2b_spacing%0d: rd gap %0d, need 18", i, rc[i] - rc[i-1]);
      end
    end
    n_checks++;
    if (coincide !== c0) begin n_fail++; $display("FAIL rd_wr_coincide: %0d cycles, need 0", coincide - c0); end
  endtask

  initial begin
    test_reset();
    test_product("small", 16'h0065, 16'h0047, 1'b0, 32'h00001C03);
    test_abort();
    test_product("isolation", 16'h00C7, 16'h0053, 1'b1, 32'h00004085);
    test_product("large", 16'h0C84, 16'h0965, 1'b0, 32'h00759414);
    test_hold(32'h00759414);
    test_product("max", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    test_product("zero", 16'h0000, 16'hFFFF, 1'b0, 32'h00000000);
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplier_module.md
MULTIPLIER_MODULE -- requirements
Module: multiplier_module

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of each operand; the product is 2*DATA_WIDTH bits.
REQ-002 Parameter FRAC_BITS, default 4: number of fraction bits in each operand (operands Q12.4, product Q24.8).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on the rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port entry_1, input, DATA_WIDTH bits: multiplicand, unsigned Q12.4.
REQ-006 Port entry_2, input, DATA_WIDTH bits: multiplier, unsigned Q12.4.
REQ-007 Port rd, output, 1 bit: read strobe to the upstream channel; high for exactly one cycle while the operands are sampled.
REQ-008 Port wr, output, 1 bit: write strobe to the downstream channel; high for exactly one cycle while output_1 presents a new product.
REQ-009 Port output_1, output, 2*DATA_WIDTH bits: registered product, unsigned Q24.8.

Function
REQ-010 The FSM SHALL have four states: IDLE, READ, COMPUTE and WRITE.
REQ-011 IDLE SHALL go to READ on the next rising edge.
REQ-012 In READ, rd SHALL be 1; on that edge entry_1 and entry_2 SHALL be latched into internal registers and the state SHALL go to COMPUTE.
REQ-013 COMPUTE SHALL run an iterative shift-add multiply of exactly DATA_WIDTH cycles, processing one multiplier bit per cycle, LSB first.
REQ-014 COMPUTE SHALL use only the latched operands; entry_1 and entry_2 SHALL be ignored outside READ.
REQ-015 After the last COMPUTE cycle, the state SHALL go to WRITE.
REQ-016 In WRITE, wr SHALL be 1 and output_1 SHALL already hold the full product; the state SHALL then return to READ.
REQ-017 Throughput SHALL be one product per DATA_WIDTH+2 cycles (18 cycles at default); rd and wr SHALL never be high in the same cycle.
REQ-018 The product SHALL be the exact unsigned full-width result entry_1*entry_2, with no rounding, truncation or saturation. The binary point SHALL sit at bit 2*FRAC_BITS.
REQ-019 output_1 SHALL hold its value between WRITE cycles and change only on entry into WRITE.
REQ-020 Boundary cases: 0 times anything SHALL give 0; 0xFFFF*0xFFFF SHALL give 0xFFFE0001 with no overflow.
REQ-021 rd and wr SHALL be driven by registered state decode only and SHALL be glitch-free.

Reset
REQ-022 While reset_n=0 the block SHALL be in IDLE with rd=0, wr=0, output_1=0, operand registers 0 and the bit counter 0, regardless of clk.
REQ-023 Asserting reset_n mid-COMPUTE or mid-WRITE SHALL abort the operation immediately; no wr pulse SHALL be produced for the aborted operands.
REQ-024 After reset_n rises, the first rd SHALL occur on the second rising edge (IDLE then READ).

Structure
REQ-025 A shared package SHALL hold the state enumeration type and the DATA_WIDTH and FRAC_BITS defaults.
REQ-026 The block SHALL be split into one control FSM and one datapath sub-module, shift_add_datapath, containing the accumulator, shifted multiplicand, multiplier shift register and bit counter.
REQ-027 No vendor multiplier primitives or the * operator SHALL be used in the datapath.

Verification
REQ-028 Reset check: hold reset_n=0 for 3 cycles -> rd=0, wr=0 and output_1=0x00000000 throughout; first rd on the 2nd edge after release.
REQ-029 Small product: entry_1=0x0065 (6.3125), entry_2=0x0047 (4.4375) during READ -> wr after 16 COMPUTE cycles with output_1=0x00001C03.
REQ-030 Operand isolation: entry_1=0x00C7, entry_2=0x0053 during READ, then random values applied during COMPUTE -> output_1=0x00004085.
REQ-031 Large product: entry_1=0x0C84, entry_2=0x0965 -> output_1=0x00759414; extremes 0xFFFF*0xFFFF -> 0xFFFE0001 and 0x0000*0xFFFF -> 0x00000000.
REQ-032 Abort: pull reset_n low in the 8th COMPUTE cycle -> no wr pulse; output_1=0 immediately; a clean restart produces a correct product.
REQ-033 Back-to-back: issue 3 operations -> rd pulses exactly 18 cycles apart, wr always 17 cycles after its rd, and rd and wr never coincident.
